// File: rtl/alu_pkg.sv
// Shared EX-stage definitions: opcode/func encodings, ALU control codes,
// and the multiply/divide FSM state encoding.
package alu_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;

    // R-type function fields
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_t;

    // mult/multu/div/divu
    function automatic logic is_md_op(input logic [5:0] func);
        return (func[5:2] == 4'b0110);
    endfunction

    // mfhi/mthi/mflo/mtlo
    function automatic logic is_hilo_move(input logic [5:0] func);
        return (func[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath: one product or quotient bit per cycle
// on unsigned magnitudes. Sign handling lives in the caller.
//  clk, rst_n     clock, async active-low reset
//  start          load operands and begin (ignored while running)
//  flush          abandon the current operation
//  is_div         1 = restoring divide, 0 = shift-add multiply
//  op_a, op_b     multiplicand/dividend, multiplier/divisor
//  done_c         final iteration happens on this cycle's edge
//  hi, lo         product high/low, or remainder/quotient
module md_iter_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done_c,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             run_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;   // product high half / partial remainder
    logic [WIDTH-1:0] sh_q;    // multiplier (shifting out) / dividend->quotient
    logic [WIDTH-1:0] opb_q;   // multiplicand / divisor

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    // One iteration of each algorithm
    always_comb begin
        mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        div_sh  = {acc_q, sh_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opb_q});
        div_rem = div_ge ? WIDTH'(div_sh - {1'b0, opb_q}) : div_sh[WIDTH-1:0];
    end

    assign done_c = run_q & (cnt_q == CNT_W'(WIDTH - 1));
    assign hi     = acc_q;
    assign lo     = sh_q;

    // Iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            sh_q  <= '0;
            opb_q <= '0;
        end else if (start && !run_q) begin
            run_q <= 1'b1;
            div_q <= is_div;
            cnt_q <= '0;
            acc_q <= '0;
            sh_q  <= is_div ? op_a : op_b;
            opb_q <= is_div ? op_b : op_a;
        end else if (run_q) begin
            if (flush) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (done_c) begin
                    run_q <= 1'b0;
                end
                if (div_q) begin
                    acc_q <= div_rem;
                    sh_q  <= {sh_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_q <= mul_sum[WIDTH:1];
                    sh_q  <= {mul_sum[0], sh_q[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/alu_md_control.sv
// EX-stage control: combinational ALU-control decode, HI/LO registers,
// multiply/divide sequencer and HI/LO hazard stall.
//  i_clk, i_rst_n   clock, async active-low reset
//  i_valid          instruction in EX is valid
//  i_flush          abort in-flight mul/div, block new acceptance
//  i_op, i_func     opcode and R-type function field
//  i_rs_data        dividend / multiplicand / MTHI-MTLO source
//  i_rt_data        divisor / multiplier
//  o_aluControl     ALU operation code
//  o_hilo_data      HI for mfhi, LO for mflo, else 0
//  o_stall          hold IF/ID/EX this cycle
//  o_md_busy        sequencer not idle
module alu_md_control
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_flush,
    input  logic [5:0]       i_op,
    input  logic [5:0]       i_func,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    output logic [3:0]       o_aluControl,
    output logic [WIDTH-1:0] o_hilo_data,
    output logic             o_stall,
    output logic             o_md_busy
);

    md_state_t        state, state_nxt;
    logic [WIDTH-1:0] hi_q, hi_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic             neg_lo_q, neg_lo_nxt;   // negate product / quotient
    logic             neg_hi_q, neg_hi_nxt;   // negate remainder
    logic             is_div_q, is_div_nxt;

    logic             rtype;
    logic             md_op;
    logic             md_class;
    logic             signed_op;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic             accept;

    logic             core_done_c;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // ALU control decode
    always_comb begin
        o_aluControl = ALU_ADD;
        if (i_op == OP_RTYPE) begin
            case (i_func)
                F_ADD, F_ADDU: o_aluControl = ALU_ADD;
                F_SUB, F_SUBU: o_aluControl = ALU_SUB;
                F_AND:         o_aluControl = ALU_AND;
                F_OR:          o_aluControl = ALU_OR;
                F_XOR:         o_aluControl = ALU_XOR;
                F_NOR:         o_aluControl = ALU_NOR;
                F_SLT:         o_aluControl = ALU_SLT;
                F_SLTU:        o_aluControl = ALU_SLTU;
                default:       o_aluControl = ALU_ADD;
            endcase
        end else begin
            case (i_op)
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW: o_aluControl = ALU_ADD;
                OP_BEQ, OP_BNE:                  o_aluControl = ALU_SUB;
                OP_ANDI:                         o_aluControl = ALU_AND;
                OP_ORI:                          o_aluControl = ALU_OR;
                OP_XORI:                         o_aluControl = ALU_XOR;
                OP_SLTI:                         o_aluControl = ALU_SLT;
                OP_SLTIU:                        o_aluControl = ALU_SLTU;
                default:                         o_aluControl = ALU_ADD;
            endcase
        end
    end

    // Operand classification; func[0]=0 marks the signed mult/div
    assign rtype     = (i_op == OP_RTYPE);
    assign md_op     = rtype & is_md_op(i_func);
    assign md_class  = rtype & (is_md_op(i_func) | is_hilo_move(i_func));
    assign signed_op = ~i_func[0];
    assign rs_neg    = signed_op & i_rs_data[WIDTH-1];
    assign rt_neg    = signed_op & i_rt_data[WIDTH-1];
    assign rs_mag    = rs_neg ? (~i_rs_data + WIDTH'(1)) : i_rs_data;
    assign rt_mag    = rt_neg ? (~i_rt_data + WIDTH'(1)) : i_rt_data;
    assign accept    = i_valid & md_op & ~i_flush & (state == MD_IDLE);

    md_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (accept),
        .flush  (i_flush),
        .is_div (i_func[1]),
        .op_a   (rs_mag),
        .op_b   (rt_mag),
        .done_c (core_done_c),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    // Sign correction of the magnitude results
    assign prod_fix = neg_lo_q ? (~{core_hi, core_lo} + (2*WIDTH)'(1)) : {core_hi, core_lo};
    assign quo_fix  = neg_lo_q ? (~core_lo + WIDTH'(1)) : core_lo;
    assign rem_fix  = neg_hi_q ? (~core_hi + WIDTH'(1)) : core_hi;

    // Sequencer next state and HI/LO updates
    always_comb begin
        state_nxt  = state;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        neg_lo_nxt = neg_lo_q;
        neg_hi_nxt = neg_hi_q;
        is_div_nxt = is_div_q;
        case (state)
            MD_IDLE: begin
                if (accept) begin
                    state_nxt  = i_func[1] ? MD_DIV : MD_MUL;
                    is_div_nxt = i_func[1];
                    // Divide by zero keeps the all-ones quotient unsigned
                    neg_lo_nxt = (rs_neg ^ rt_neg) & ~(i_func[1] & (i_rt_data == '0));
                    neg_hi_nxt = i_func[1] & rs_neg;
                end else if (i_valid && rtype && !i_flush) begin
                    if (i_func == F_MTHI) hi_nxt = i_rs_data;
                    if (i_func == F_MTLO) lo_nxt = i_rs_data;
                end
            end
            MD_MUL, MD_DIV: begin
                if (i_flush)          state_nxt = MD_IDLE;
                else if (core_done_c) state_nxt = MD_FIX;
            end
            MD_FIX: begin
                state_nxt = MD_IDLE;
                if (!i_flush) begin
                    if (is_div_q) begin
                        hi_nxt = rem_fix;
                        lo_nxt = quo_fix;
                    end else begin
                        {hi_nxt, lo_nxt} = prod_fix;
                    end
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // State and HI/LO registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= MD_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
            neg_lo_q <= neg_lo_nxt;
            neg_hi_q <= neg_hi_nxt;
            is_div_q <= is_div_nxt;
        end
    end

    assign o_md_busy = (state != MD_IDLE);
    assign o_stall   = i_valid & md_class & o_md_busy & ~i_flush;

    // HI/LO read mux; meaningful only when not stalled
    always_comb begin
        o_hilo_data = '0;
        if (rtype && i_func == F_MFHI) o_hilo_data = hi_q;
        if (rtype && i_func == F_MFLO) o_hilo_data = lo_q;
    end

endmodule

// File: tb/tb_alu_md_control.sv
module tb_alu_md_control;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic             i_flush;
    logic [5:0]       i_op;
    logic [5:0]       i_func;
    logic [WIDTH-1:0] i_rs_data;
    logic [WIDTH-1:0] i_rt_data;
    logic [3:0]       o_aluControl;
    logic [WIDTH-1:0] o_hilo_data;
    logic             o_stall;
    logic             o_md_busy;

    int checks = 0;
    int errors = 0;

    alu_md_control #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_flush      (i_flush),
        .i_op         (i_op),
        .i_func       (i_func),
        .i_rs_data    (i_rs_data),
        .i_rt_data    (i_rt_data),
        .o_aluControl (o_aluControl),
        .o_hilo_data  (o_hilo_data),
        .o_stall      (o_stall),
        .o_md_busy    (o_md_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic [3:0] exp;
    } dec_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic f, input logic [5:0] op, input logic [5:0] func,
                          input logic [31:0] rs, input logic [31:0] rt);
        i_valid   = v;
        i_flush   = f;
        i_op      = op;
        i_func    = func;
        i_rs_data = rs;
        i_rt_data = rt;
    endtask

    // Architectural result of an MD instruction, straight from integer arithmetic
    function automatic void model_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint p;
        logic [63:0] pu;
        int a, b;
        hi = '0;
        lo = '0;
        case (f)
            F_MULT: begin
                p = longint'($signed(rs)) * longint'($signed(rt));
                {hi, lo} = p;
            end
            F_MULTU: begin
                pu = 64'(rs) * 64'(rt);
                {hi, lo} = pu;
            end
            F_DIV: begin
                if (rt == 0) begin
                    lo = 32'hFFFF_FFFF; hi = rs;
                end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 0;
                end else begin
                    a = $signed(rs);
                    b = $signed(rt);
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                if (rt == 0) begin
                    lo = 32'hFFFF_FFFF; hi = rs;
                end else begin
                    lo = rs / rt;
                    hi = rs % rt;
                end
            end
        endcase
    endfunction

    // Issue one MD op, then an mfhi that waits out the stall, then an mflo
    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        set_in(1, 0, OP_RTYPE, f, rs, rt);
        tick();
        set_in(1, 0, OP_RTYPE, F_MFHI, 0, 0);
        n = 0;
        @(negedge i_clk);
        while (o_stall && n < 100) begin
            n++;
            tick();
            @(negedge i_clk);
        end
        check({name, " stall_cycles"}, 32'(n), 32'(WIDTH + 1));
        check({name, " hi"}, o_hilo_data, exp_hi);
        set_in(1, 0, OP_RTYPE, F_MFLO, 0, 0);
        #1;
        check({name, " lo"}, o_hilo_data, exp_lo);
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        tick();
    endtask

    initial begin
        dec_vec_t   vecs[$];
        logic [31:0] eh, el, rs, rt;
        logic [5:0]  f;
        int          n, sel;
        logic        stall_seen;

        // Decode table: op, func, expected ALU code
        vecs.push_back('{OP_RTYPE, 6'b100000, 4'b0010});
        vecs.push_back('{OP_RTYPE, 6'b100001, 4'b0010});
        vecs.push_back('{OP_RTYPE, 6'b100010, 4'b0110});
        vecs.push_back('{OP_RTYPE, 6'b100011, 4'b0110});
        vecs.push_back('{OP_RTYPE, 6'b100100, 4'b0000});
        vecs.push_back('{OP_RTYPE, 6'b100101, 4'b0001});
        vecs.push_back('{OP_RTYPE, 6'b100110, 4'b0011});
        vecs.push_back('{OP_RTYPE, 6'b100111, 4'b1100});
        vecs.push_back('{OP_RTYPE, 6'b101010, 4'b0111});
        vecs.push_back('{OP_RTYPE, 6'b101011, 4'b1000});
        vecs.push_back('{OP_RTYPE, 6'b111111, 4'b0010});
        vecs.push_back('{OP_RTYPE, 6'b011000, 4'b0010});
        vecs.push_back('{6'b001000, 6'b100111, 4'b0010});
        vecs.push_back('{6'b001001, 6'b100111, 4'b0010});
        vecs.push_back('{6'b100011, 6'b100111, 4'b0010});
        vecs.push_back('{6'b101011, 6'b100111, 4'b0010});
        vecs.push_back('{6'b000100, 6'b100111, 4'b0110});
        vecs.push_back('{6'b000101, 6'b100100, 4'b0110});
        vecs.push_back('{6'b001100, 6'b100111, 4'b0000});
        vecs.push_back('{6'b001101, 6'b100111, 4'b0001});
        vecs.push_back('{6'b001110, 6'b100111, 4'b0011});
        vecs.push_back('{6'b001010, 6'b100111, 4'b0111});
        vecs.push_back('{6'b001011, 6'b100111, 4'b1000});
        vecs.push_back('{6'b111111, 6'b100010, 4'b0010});

        i_rst_n = 1'b0;
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        repeat (2) @(posedge i_clk);
        #1;
        set_in(1, 0, OP_RTYPE, F_MFHI, 0, 0);
        #1;
        check("reset busy", 32'(o_md_busy), 0);
        check("reset stall", 32'(o_stall), 0);
        check("reset hi", o_hilo_data, 0);
        i_func = F_MFLO;
        #1;
        check("reset lo", o_hilo_data, 0);
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        i_rst_n = 1'b1;
        tick();

        // Decode sweep
        foreach (vecs[i]) begin
            set_in(0, 0, vecs[i].op, vecs[i].func, 32'(i), 0);
            #2;
            check($sformatf("decode op=%b func=%b", vecs[i].op, vecs[i].func),
                  32'(o_aluControl), 32'(vecs[i].exp));
        end
        tick();

        // Directed MD corner cases
        run_md("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_md("div_neg_by0", F_DIV, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF);

        // divu by zero with an unrelated add issued throughout the busy window
        set_in(1, 0, OP_RTYPE, F_DIVU, 32'h1234_5678, 0);
        tick();
        set_in(1, 0, OP_RTYPE, F_ADD, 1, 2);
        n = 0;
        stall_seen = 1'b0;
        @(negedge i_clk);
        while (o_md_busy && n < 100) begin
            stall_seen |= o_stall;
            n++;
            tick();
            @(negedge i_clk);
        end
        check("divu0 add_no_stall", 32'(stall_seen), 0);
        check("divu0 busy_cycles", 32'(n), 32'(WIDTH + 1));
        check("divu0 add_alu", 32'(o_aluControl), 32'(4'b0010));
        set_in(1, 0, OP_RTYPE, F_MFHI, 0, 0);
        #1;
        check("divu0 hi", o_hilo_data, 32'h1234_5678);
        i_func = F_MFLO;
        #1;
        check("divu0 lo", o_hilo_data, 32'hFFFF_FFFF);
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        tick();

        // Flush in IDLE blocks acceptance
        set_in(1, 1, OP_RTYPE, F_MULT, 5, 6);
        tick();
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        check("idle_flush no_accept", 32'(o_md_busy), 0);

        // Flush mid-multiply keeps prior HI/LO
        set_in(1, 0, OP_RTYPE, F_MTHI, 32'hAAAA_5555, 0);
        tick();
        set_in(1, 0, OP_RTYPE, F_MTLO, 32'h5555_AAAA, 0);
        tick();
        set_in(1, 0, OP_RTYPE, F_MULT, 32'h0000_1234, 32'h0000_5678);
        tick();
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        repeat (9) tick();
        set_in(1, 1, OP_RTYPE, F_MFHI, 0, 0);
        #1;
        check("flush busy_before", 32'(o_md_busy), 1);
        check("flush stall_masked", 32'(o_stall), 0);
        tick();
        set_in(1, 0, OP_RTYPE, F_MFHI, 0, 0);
        #1;
        check("flush busy_after", 32'(o_md_busy), 0);
        check("flush hi_kept", o_hilo_data, 32'hAAAA_5555);
        i_func = F_MFLO;
        #1;
        check("flush lo_kept", o_hilo_data, 32'h5555_AAAA);
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        tick();

        // Asynchronous reset mid-operation
        set_in(1, 0, OP_RTYPE, F_MULT, 32'h0000_0100, 32'h0000_0200);
        tick();
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        repeat (4) tick();
        #1;
        i_rst_n = 1'b0;
        #1;
        check("rst busy", 32'(o_md_busy), 0);
        set_in(1, 0, OP_RTYPE, F_MFHI, 0, 0);
        #1;
        check("rst stall", 32'(o_stall), 0);
        check("rst hi", o_hilo_data, 0);
        i_func = F_MFLO;
        #1;
        check("rst lo", o_hilo_data, 0);
        set_in(0, 0, 6'd0, 6'd0, 0, 0);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        tick();
        run_md("mult_3_m4", F_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

        // Randomized MD ops against the arithmetic model
        for (int k = 0; k < 30; k++) begin
            f   = F_MULT + 6'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            rs  = $urandom;
            rt  = $urandom;
            if (sel == 0) rt = 0;
            else if (sel == 1) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
            else if (sel == 2) rt = 32'($urandom_range(1, 20));
            else if (sel == 3) rt = -32'($urandom_range(1, 20));
            model_md(f, rs, rt, eh, el);
            run_md($sformatf("rand%0d f=%b rs=%h rt=%h", k, f, rs, rt), f, rs, rt, eh, el);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
